// File: rtl/msk_fifo_sched_pkg.sv
// ============================================================================
// msk_fifo_sched_pkg
// Shared types for the masked shift-FIFO scheduler: control states,
// one-hot slot actions and the level-width helper.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package msk_fifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

    // One-hot slot select; only public control ever drives these bits.
    typedef logic [3:0] slot_act_t;
    localparam slot_act_t c_act_hold  = 4'b0001;
    localparam slot_act_t c_act_shift = 4'b0010;
    localparam slot_act_t c_act_load  = 4'b0100;
    localparam slot_act_t c_act_zero  = 4'b1000;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/msk_fifo_sched_slot.sv
// ============================================================================
// msk_fifo_sched_slot
// One masked entry register with a public one-hot select: hold, shift-in,
// load-in and, when MSK_FIFO_ZEROIZE_EN is defined, zero.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

(* fv_strat = "flatten" *)
module msk_fifo_sched_slot
    import msk_fifo_sched_pkg::*;
#(
    parameter int W = 2
) (
    input  logic                                        clk,
    input  slot_act_t                                   i_sel,
    (* fv_type = "sharing", fv_latency = 0 *) input  logic [W-1:0] i_shift,
    (* fv_type = "sharing", fv_latency = 0 *) input  logic [W-1:0] i_load,
    (* fv_type = "sharing", fv_latency = 1 *) output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Each share lane is a plain enabled register; lanes never combine.
    always_ff @(posedge clk) begin
        case (i_sel)
            c_act_shift: r_q <= i_shift;
            c_act_load:  r_q <= i_load;
`ifdef MSK_FIFO_ZEROIZE_EN
            c_act_zero:  r_q <= '0;
`endif
            default:     r_q <= r_q;
        endcase
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/msk_fifo_sched.sv
// ============================================================================
// msk_fifo_sched
// Masked shift-FIFO between gadgets of differing throughput; slot enables
// and fill level come only from the public handshake. Option: MSK_FIFO_ZEROIZE_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module msk_fifo_sched
    import msk_fifo_sched_pkg::*;
#(
    parameter int D     = 2,
    parameter int COUNT = 1,
    parameter int DEPTH = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    (* fv_type = "sharing", fv_latency = 0 *) input  logic [COUNT*D-1:0] in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    (* fv_type = "sharing", fv_latency = 1 *) output logic [COUNT*D-1:0] out_data,
    output logic [level_width(DEPTH)-1:0]                  level
);

    localparam int c_w  = COUNT * D;
    localparam int c_lw = level_width(DEPTH);
    localparam logic [c_lw-1:0] c_one      = c_lw'(1);
    localparam logic [c_lw-1:0] c_last_lvl = c_lw'(DEPTH - 1);

    fifo_state_t       r_state;
    fifo_state_t       w_state_next;
    logic [c_lw-1:0]   r_level;
    logic [c_lw-1:0]   w_level_next;
    logic              w_push;
    logic              w_pop;
    int                w_lvl_i;
    slot_act_t         w_act [DEPTH];
    logic [c_w-1:0]    w_q   [DEPTH];

    assign in_ready  = !rst && (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_lvl_i   = int'(r_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_level <= '0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_one;
            if (r_state == ST_EMPTY)
                w_state_next = ST_PARTIAL;
            else if (r_state == ST_PARTIAL && r_level == c_last_lvl)
                w_state_next = ST_FULL;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - c_one;
            if (r_state == ST_FULL)
                w_state_next = ST_PARTIAL;
            else if (r_state == ST_PARTIAL && r_level == c_one)
                w_state_next = ST_EMPTY;
        end
    end

    // Action decode: exactly one select bit per slot, derived from level only.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_act[i] = c_act_hold;
            if (rst) begin
`ifdef MSK_FIFO_ZEROIZE_EN
                w_act[i] = c_act_zero;
`endif
            end else if (w_pop && !w_push) begin
                if (i < w_lvl_i - 1)
                    w_act[i] = c_act_shift;
`ifdef MSK_FIFO_ZEROIZE_EN
                else if (i == w_lvl_i - 1)
                    w_act[i] = c_act_zero;
`endif
            end else if (w_push && !w_pop) begin
                if (i == w_lvl_i)
                    w_act[i] = c_act_load;
            end else if (w_push && w_pop) begin
                if (i < w_lvl_i - 1)
                    w_act[i] = c_act_shift;
                else if (i == w_lvl_i - 1)
                    w_act[i] = c_act_load;
            end
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [c_w-1:0] w_shift_src;
            if (i < DEPTH - 1) begin : g_mid
                assign w_shift_src = w_q[i+1];
            end else begin : g_tail
                // The tail slot is never shifted into; tie off.
                assign w_shift_src = '0;
            end
            msk_fifo_sched_slot #(.W(c_w)) u_slot (
                .clk     (clk),
                .i_sel   (w_act[i]),
                .i_shift (w_shift_src),
                .i_load  (in_data),
                .o_q     (w_q[i])
            );
        end
    endgenerate

    assign out_data = w_q[0];
    assign level    = r_level;

endmodule

`default_nettype wire

// File: tb/tb_msk_fifo_sched.sv
// ============================================================================
// tb_msk_fifo_sched
// Directed scenarios plus random traffic against a queue-based model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msk_fifo_sched;

    localparam int c_d     = 2;
    localparam int c_count = 1;
    localparam int c_depth = 4;
    localparam int c_w     = c_d * c_count;
    localparam int c_lw    = $clog2(c_depth + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [c_w-1:0]    in_data;
    logic              out_valid;
    logic              out_ready;
    logic [c_w-1:0]    out_data;
    logic [c_lw-1:0]   level;

    int n_cmp = 0;
    int n_err = 0;

    logic [c_w-1:0] model_q[$];

    always #5 clk = ~clk;

    msk_fifo_sched #(.D(c_d), .COUNT(c_count), .DEPTH(c_depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, apply the edge.
    task automatic cycle(input logic r, input logic iv, input logic [c_w-1:0] dat,
                         input logic ordy);
        logic exp_ir;
        logic do_push;
        logic do_pop;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        #1;
        exp_ir  = !r && (model_q.size() < c_depth);
        do_push = iv && exp_ir;
        do_pop  = (model_q.size() != 0) && ordy && !r;
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, model_q.size() != 0);
        check("level", level, model_q.size());
        if (model_q.size() != 0)
            check("out_data", out_data, model_q[0]);
`ifdef MSK_FIFO_ZEROIZE_EN
        else
            check("out_data_zero", out_data, 0);
`endif
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(dat);
        end
    endtask

    initial begin
        logic [c_w-1:0] fill_pat [4];
        fill_pat[0] = 2'b01;
        fill_pat[1] = 2'b11;
        fill_pat[2] = 2'b00;
        fill_pat[3] = 2'b10;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        model_q.delete();

        // Reset held, then idle.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Fill to FULL, then attempt a push while full.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, fill_pat[i], 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b0);

        // Drain from FULL and one idle cycle after.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Simultaneous push/pop at level 1.
        cycle(1'b0, 1'b1, 2'b10, 1'b0);
        cycle(1'b0, 1'b1, 2'b01, 1'b1);
        cycle(1'b0, 1'b1, 2'b11, 1'b1);
        // Grow to level 3 and push/pop there.
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        cycle(1'b0, 1'b1, 2'b10, 1'b0);
        cycle(1'b0, 1'b1, 2'b01, 1'b1);
        cycle(1'b0, 1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Push attempt while FULL with out_ready high, then push accepted.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, fill_pat[i], 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b1);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset at level 2, then the next push emerges first.
        cycle(1'b0, 1'b1, 2'b01, 1'b0);
        cycle(1'b0, 1'b1, 2'b10, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b1);
        cycle(1'b0, 1'b1, 2'b11, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)),
                  c_w'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
